// File: rtl/block_pe_pkg.sv
// block_pe_pkg: shared types and sizing helpers for the block_pe_n tile.
//   alu_op_e    - ALU operation encodings (ALU_ADD..ALU_SHR)
//   mem_mode_e  - scratchpad mode encodings
//   cfg_ctrl_t  - packed control fields sitting between the selects and the constant
//   sel_w/cfg_w - source-select width and total config chain length
package block_pe_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_MUL = 3'd2,
      ALU_AND = 3'd3,
      ALU_OR  = 3'd4,
      ALU_XOR = 3'd5,
      ALU_SHL = 3'd6,
      ALU_SHR = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      MEM_IDLE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2,
      MEM_RSVD  = 2'd3
   } mem_mode_e;

   // Packed MSB first, so alu_en lands at the lowest bit of the field.
   typedef struct packed {
      logic      out_sel;
      mem_mode_e mem_mode;
      alu_op_e   alu_op;
      logic      alu_en;
   } cfg_ctrl_t;

   localparam int unsigned CTRL_W = $bits(cfg_ctrl_t);

   function automatic int unsigned sel_w(int unsigned num_in);
      return $clog2(num_in + 3);
   endfunction

   function automatic int unsigned cfg_w(int unsigned width, int unsigned num_in);
      return 4 * sel_w(num_in) + CTRL_W + width;
   endfunction

endpackage

// File: rtl/block_pe_n_if.sv
// block_pe_n_if: data-side bundle of one PE tile.
//   in_data/in_valid - NUM_IN operands (input i at [i*WIDTH +: WIDTH]) with per-input valid
//   out0/out0_valid  - registered result and its one-cycle valid
// master drives operands and observes the result; slave is the PE side.
interface block_pe_n_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [WIDTH-1:0]        out0;
   logic                    out0_valid;

   modport master (output in_data, in_valid, input out0, out0_valid);
   modport slave  (input in_data, in_valid, output out0, out0_valid);
endinterface

// File: rtl/pe_scratchpad.sv
// pe_scratchpad: DEPTH x WIDTH synchronous RAM with a registered read port.
//   clk, reset  - clock, synchronous active-low reset (clears read register only)
//   wr_en/rd_en - write and read strobes (never both set by the PE)
//   addr, wdata - shared address, write data
//   rdata       - last word read; holds when no read
//   rvalid      - high for the cycle after a read
module pe_scratchpad #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;
   logic             rvalid_q;

   // Contents survive reset; writes are simply suppressed while it is held.
   always_ff @(posedge clk) begin
      if (reset && wr_en) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rd_en;
         if (rd_en) begin
            rdata_q <= mem[addr];
         end
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
endmodule

// File: rtl/block_pe_n.sv
// block_pe_n: CGRA tile with NUM_IN gated inputs, registered ALU with feedback,
// DEPTH-word scratchpad and a serially loaded configuration word.
//   clk, reset           - clock, synchronous active-low reset
//   config_en, config_in - shift enable and serial bit from the upstream tile
//   config_out           - serial bit to the downstream tile (cfg[0])
//   io (slave)           - operands in, registered result out
module block_pe_n
   import block_pe_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned DEPTH  = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          config_en,
   input  logic          config_in,
   output logic          config_out,
   block_pe_n_if.slave   io
);
   localparam int unsigned SELW  = sel_w(NUM_IN);
   localparam int unsigned CFGW  = cfg_w(WIDTH, NUM_IN);
   localparam int unsigned NSLOT = 2 ** SELW;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned SHW   = $clog2(WIDTH);

   logic [CFGW-1:0]  cfg_q;
   logic [WIDTH-1:0] alu_q, alu_d, mem_q;
   logic             alu_v_q, mem_v;

   logic [SELW-1:0]  sel_a, sel_b, sel_addr, sel_wdata;
   cfg_ctrl_t        ctrl;
   logic [WIDTH-1:0] const_val;

   assign sel_a     = cfg_q[0*SELW +: SELW];
   assign sel_b     = cfg_q[1*SELW +: SELW];
   assign sel_addr  = cfg_q[2*SELW +: SELW];
   assign sel_wdata = cfg_q[3*SELW +: SELW];
   assign ctrl      = cfg_ctrl_t'(cfg_q[4*SELW +: CTRL_W]);
   assign const_val = cfg_q[CFGW-1 -: WIDTH];

   // Source table padded to a power of two; unused codes read as invalid zero.
   logic [WIDTH-1:0] src_val [NSLOT];
   logic [NSLOT-1:0] src_vld;

   for (genvar i = 0; i < NSLOT; i++) begin : g_src
      if (i < NUM_IN) begin : g_in
         assign src_val[i] = io.in_data[i*WIDTH +: WIDTH];
         assign src_vld[i] = io.in_valid[i];
      end else if (i == NUM_IN) begin : g_alu
         assign src_val[i] = alu_q;
         assign src_vld[i] = 1'b1;
      end else if (i == NUM_IN + 1) begin : g_mem
         assign src_val[i] = mem_q;
         assign src_vld[i] = 1'b1;
      end else if (i == NUM_IN + 2) begin : g_const
         assign src_val[i] = const_val;
         assign src_vld[i] = 1'b1;
      end else begin : g_none
         assign src_val[i] = '0;
         assign src_vld[i] = 1'b0;
      end
   end

   logic [WIDTH-1:0] a_val, b_val, addr_val, wd_val;
   logic             fire_alu, fire_load, fire_store;
   logic             unused_addr_hi;

   assign a_val    = src_val[sel_a];
   assign b_val    = src_val[sel_b];
   assign addr_val = src_val[sel_addr];
   assign wd_val   = src_val[sel_wdata];
   assign unused_addr_hi = ^addr_val[WIDTH-1:AW];

   assign fire_alu   = ~config_en & ctrl.alu_en & src_vld[sel_a] & src_vld[sel_b];
   assign fire_load  = ~config_en & (ctrl.mem_mode == MEM_LOAD) & src_vld[sel_addr];
   assign fire_store = ~config_en & (ctrl.mem_mode == MEM_STORE) & src_vld[sel_addr]
                       & src_vld[sel_wdata];

   always_comb begin
      alu_d = alu_q;
      unique case (ctrl.alu_op)
         ALU_ADD: alu_d = a_val + b_val;
         ALU_SUB: alu_d = a_val - b_val;
         ALU_MUL: alu_d = a_val * b_val;
         ALU_AND: alu_d = a_val & b_val;
         ALU_OR:  alu_d = a_val | b_val;
         ALU_XOR: alu_d = a_val ^ b_val;
         ALU_SHL: alu_d = a_val << b_val[SHW-1:0];
         ALU_SHR: alu_d = a_val >> b_val[SHW-1:0];
         default: alu_d = alu_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cfg_q   <= '0;
         alu_q   <= '0;
         alu_v_q <= 1'b0;
      end else begin
         if (config_en) begin
            cfg_q <= {config_in, cfg_q[CFGW-1:1]};
         end
         if (fire_alu) begin
            alu_q <= alu_d;
         end
         alu_v_q <= fire_alu;
      end
   end

   pe_scratchpad #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_spad (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (fire_store),
      .rd_en  (fire_load),
      .addr   (addr_val[AW-1:0]),
      .wdata  (wd_val),
      .rdata  (mem_q),
      .rvalid (mem_v)
   );

   assign config_out    = cfg_q[0];
   assign io.out0       = ctrl.out_sel ? mem_q : alu_q;
   assign io.out0_valid = ctrl.out_sel ? mem_v : alu_v_q;
endmodule
